// File: rtl/sar_search_ctrl_if.sv
// Comparator-facing bundle for sar_search_ctrl: start request, comparator results, trial code and search status.
interface sar_search_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             cmp_eq;
  logic             cmp_gt;
  logic             cmp_sm;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    input  start, cmp_eq, cmp_gt, cmp_sm,
    output trial, busy, done, result, err
  );

  modport slave (
    output start, cmp_eq, cmp_gt, cmp_sm,
    input  trial, busy, done, result, err
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial codes MSB-first and resolves the comparator's target.
// Optional macro SAR_EARLY_EXIT_EN: a legal cmp_eq ends the search at that compare cycle.
module sar_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sar_search_ctrl_if.master bus
);

  typedef enum logic {
    IDLE,
    SEARCH
  } state_t;

  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q;
  logic [WIDTH-1:0] trial_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             legal;
  logic             keep;
  logic             hit;
  logic             last;
  logic [WIDTH-1:0] decided;

  // Legal means exactly one result line high; anything else is decided as "smaller".
  always_comb begin
    legal   = (bus.cmp_eq ^ bus.cmp_gt ^ bus.cmp_sm) & ~(bus.cmp_eq & bus.cmp_gt & bus.cmp_sm);
    keep    = legal & (bus.cmp_eq | bus.cmp_gt);
    decided = keep ? trial_q : (trial_q & ~mask_q);
`ifdef SAR_EARLY_EXIT_EN
    hit     = legal & bus.cmp_eq;
`else
    hit     = 1'b0;
`endif
    last    = mask_q[0] | hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      mask_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            trial_q <= MSB;
            mask_q  <= MSB;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          if (!legal) err_q <= 1'b1;
          if (last) begin
            trial_q  <= decided;
            result_q <= decided;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            mask_q   <= '0;
            state_q  <= IDLE;
          end else begin
            trial_q <= decided | (mask_q >> 1);
            mask_q  <= mask_q >> 1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl (WIDTH=4) with a behavioural comparator against a settable target.
module tb_sar_search_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] target;
  logic         force_ill;
  int           n_cmp;
  int           n_bad;

  sar_search_ctrl_if #(.WIDTH(W)) bus ();

  sar_search_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External comparator: A = target, B = trial; force_ill drives gt and sm together.
  assign bus.cmp_eq = force_ill ? 1'b0 : (target == bus.trial);
  assign bus.cmp_gt = force_ill ? 1'b1 : (target >  bus.trial);
  assign bus.cmp_sm = force_ill ? 1'b1 : (target <  bus.trial);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller sets target/start at a negedge; the next posedge samples start.
  task automatic run_search(input string name, input int ntr,
                            input logic [W-1:0] t0, input logic [W-1:0] t1,
                            input logic [W-1:0] t2, input logic [W-1:0] t3,
                            input logic [W-1:0] exp_res, input int ill_idx,
                            input bit keep_start);
    logic [W-1:0] tr [4];
    logic         exp_err;
    tr = '{t0, t1, t2, t3};
    @(negedge clk);
    if (!keep_start) bus.start = 1'b0;
    for (int i = 0; i < ntr; i++) begin
      exp_err   = (ill_idx >= 0) && (i > ill_idx);
      force_ill = (i == ill_idx);
      n_cmp++;
      if ({bus.busy, bus.done, bus.trial, bus.err} !== {1'b1, 1'b0, tr[i], exp_err}) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got busy=%b done=%b trial=%0d err=%b, want busy=1 done=0 trial=%0d err=%b",
                 name, i + 1, bus.busy, bus.done, bus.trial, bus.err, tr[i], exp_err);
      end
      @(negedge clk);
      force_ill = 1'b0;
    end
    exp_err = (ill_idx >= 0);
    n_cmp++;
    if ({bus.busy, bus.done, bus.result, bus.err} !== {1'b0, 1'b1, exp_res, exp_err}) begin
      n_bad++;
      $display("FAIL %s done: got busy=%b done=%b result=%0d err=%b, want busy=0 done=1 result=%0d err=%b",
               name, bus.busy, bus.done, bus.result, bus.err, exp_res, exp_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    target = '0;
    force_ill = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.trial, bus.busy, bus.done, bus.result, bus.err} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got trial=%0d busy=%b done=%b result=%0d err=%b, want all 0",
               bus.trial, bus.busy, bus.done, bus.result, bus.err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.trial, bus.busy, bus.done, bus.result, bus.err} !== '0) begin
      n_bad++;
      $display("FAIL idle_no_start: got trial=%0d busy=%b done=%b result=%0d err=%b, want all 0",
               bus.trial, bus.busy, bus.done, bus.result, bus.err);
    end
  endtask

  task automatic test_target11();
    target = 4'd11;
    bus.start = 1'b1;
    run_search("t11", 4, 4'd8, 4'd12, 4'd10, 4'd11, 4'd11, -1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.result} !== {1'b0, 1'b0, 4'd11}) begin
      n_bad++;
      $display("FAIL t11_after: got busy=%b done=%b result=%0d, want busy=0 done=0 result=11",
               bus.busy, bus.done, bus.result);
    end
  endtask

  task automatic test_target8();
    target = 4'd8;
    bus.start = 1'b1;
`ifdef SAR_EARLY_EXIT_EN
    run_search("t8", 1, 4'd8, 4'd0, 4'd0, 4'd0, 4'd8, -1, 1'b0);
`else
    run_search("t8", 4, 4'd8, 4'd12, 4'd10, 4'd9, 4'd8, -1, 1'b0);
`endif
    @(negedge clk);
  endtask

  task automatic test_bounds();
    target = 4'd0;
    bus.start = 1'b1;
    run_search("t0", 4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd0, -1, 1'b0);
    @(negedge clk);
    target = 4'd15;
    bus.start = 1'b1;
    run_search("t15", 4, 4'd8, 4'd12, 4'd14, 4'd15, 4'd15, -1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    target = 4'd11;
    bus.start = 1'b1;
    run_search("b2b_a", 4, 4'd8, 4'd12, 4'd10, 4'd11, 4'd11, -1, 1'b1);
    target = 4'd3;
    run_search("b2b_b", 4, 4'd8, 4'd4, 4'd2, 4'd3, 4'd3, -1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.result} !== {1'b0, 1'b0, 4'd3}) begin
      n_bad++;
      $display("FAIL b2b_after: got busy=%b done=%b result=%0d, want busy=0 done=0 result=3",
               bus.busy, bus.done, bus.result);
    end
  endtask

  task automatic test_illegal();
    target = 4'd11;
    bus.start = 1'b1;
    run_search("illegal", 4, 4'd8, 4'd12, 4'd10, 4'd11, 4'd11, 1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({bus.err, bus.done} !== 2'b10) begin
      n_bad++;
      $display("FAIL err_sticky: got err=%b done=%b, want err=1 done=0", bus.err, bus.done);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if ({bus.err, bus.busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL err_clear: got err=%b busy=%b, want err=0 busy=1", bus.err, bus.busy);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.result, bus.err} !== {1'b1, 4'd11, 1'b0}) begin
      n_bad++;
      $display("FAIL err_clean_run: got done=%b result=%0d err=%b, want done=1 result=11 err=0",
               bus.done, bus.result, bus.err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    target = 4'd11;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.trial, bus.busy, bus.done, bus.result, bus.err} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got trial=%0d busy=%b done=%b result=%0d err=%b, want all 0",
               bus.trial, bus.busy, bus.done, bus.result, bus.err);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_no_done cycle %0d: got done=%b, want 0", i, bus.done);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    target = 4'd5;
    bus.start = 1'b1;
    run_search("t5", 4, 4'd8, 4'd4, 4'd6, 4'd5, 4'd5, -1, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_target11();
    test_target8();
    test_bounds();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation search controller: the driving end of a magnitude-comparator interface.
- On start, it drives trial codes to an external comparator, one per cycle, MSB first. Comparison is A = unknown target, B = trial.
- It consumes the equal/greater/smaller result of each comparison and resolves the unknown target value in at most WIDTH compare cycles.
- Used wherever a comparator sits against an unknown quantity: threshold search, SAR-style conversion, key lookup.

Parameters:
- WIDTH, 4, bit width of the trial code, target and result; must be >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new search; sampled only when idle.
- cmp_eq  input  1  comparator result: target == trial.
- cmp_gt  input  1  comparator result: target > trial.
- cmp_sm  input  1  comparator result: target < trial.
- trial  output  WIDTH  code presented to the comparator B input (registered).
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  WIDTH  resolved target value; held until the next done.
- err  output  1  sticky flag: an illegal comparator code was seen during the current or last search.

Behaviour:
- Interface, fixed: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: trial=0, busy=0, done=0, result=0, err=0, state=IDLE, bit mask=0.
- States: IDLE and SEARCH. An internal one-hot mask register marks the bit under test.
- Comparator is external and combinational. cmp_* are evaluated in the same cycle that trial is presented; no input registering.
- IDLE:
  - trial holds its last value.
  - On start=1 at an edge: trial <= 1<<(WIDTH-1), mask <= 1<<(WIDTH-1), busy <= 1, err <= 0, state -> SEARCH.
- SEARCH, each edge, bit decision:
  - cmp_eq=1 or cmp_gt=1: keep the mask bit set in trial.
  - cmp_sm=1: clear the mask bit in trial.
- SEARCH, same edge, step:
  - If mask[0]=0: set the next lower bit in trial, mask >>= 1.
  - If mask[0]=1 (last bit): result <= final trial after the decision, done <= 1, busy <= 0, state -> IDLE.
- Illegal comparator code (not exactly one of eq/gt/sm high): err <= 1, and the bit is decided as cmp_sm.
- Latency: start sampled at edge 0; compare cycles 1..WIDTH; done high in cycle WIDTH+1. Throughput is one search per WIDTH+1 cycles.
- done is a single-cycle pulse and is deasserted on the following edge unconditionally.
- start while busy: ignored, no queuing.
- start high in the done cycle: accepted (state is IDLE), and the next search begins.
- result changes only on done. err clears only on an accepted start or reset.
- Target 0 resolves to 0; target 2^WIDTH-1 resolves to all-ones. No wrap-around: trial never exceeds 2^WIDTH-1.
- Reset mid-search: every output returns to its reset value immediately (asynchronous); no done is produced.

Optional Feature:
- Macro: SAR_EARLY_EXIT_EN.
- Defined: in SEARCH, a legal cmp_eq=1 terminates the search at that edge. result <= current trial (bit kept, lower bits remain 0), done=1 next cycle, busy=0, state -> IDLE. Latency is k+1 for a match at compare cycle k.
- Undefined: cmp_eq is treated as cmp_gt, and every search takes exactly WIDTH compare cycles.
- Final result values are identical in both builds; only latency differs.

Test Plan:
- WIDTH=4, target 11, no macro -> trials 8,12,10,11; result=11; done pulse in cycle 5; busy high cycles 1-4; err=0.
- Target 8 -> without macro: trials 8,12,10,9, result=8, done cycle 5. With SAR_EARLY_EXIT_EN: trial 8 only, result=8, done cycle 2.
- Targets 0 and 15 -> results 0 and 15 respectively.
  - Target 0: trials 8,4,2,1, all cmp_sm.
  - Target 15: trials 8,12,14,15; bits kept on cmp_gt and final cmp_eq.
- Back-to-back: start held high across done, target changed 11->3 -> second search begins in the done cycle, result=3.
  - start pulses during busy have no effect.
- Forced cmp_gt=cmp_sm=1 on compare cycle 2 (target 11) -> err=1, bit 2 cleared (treated as cmp_sm).
  - err stays 1 after done; it clears on the next accepted start.
- rst_n low during compare cycle 3 -> all outputs 0 immediately; no done.
  - After release, a fresh start with target 5 gives result=5.
